// File: rtl/updown_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// updown_ctrl_pkg
// Shared types and constants for the up/down counting controller: the FSM
// state encoding, the run-mode codes driven by the board controls and the
// direction encoding used on dir_req / dir.
// -----------------------------------------------------------------------------
package updown_ctrl_pkg;

    // Controller states; HOLD remembers the direction in the dir register.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2,
        HOLD     = 2'd3
    } state_e;

    // Run modes; 2'b11 is not listed and behaves like wrap.
    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_WRAP     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    // Direction encoding.
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Divider that produces a one-cycle tick strobe every DIV_MAX+1 running cycles.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-low reset
//   run  : divider advances on cycles where this is high, otherwise freezes
//   clr  : clears the divider and any pending tick (wins over run)
//   tick : registered one-cycle strobe
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter logic [31:0] DIV_MAX = 32'd49_999_999
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    logic [31:0] div_q, div_d;
    logic        wrap_q, wrap_d;
    logic        tick_q, tick_d;

    // The wrap flag records that the divider just rolled over; the tick is
    // issued on the next running cycle. Keeping the flag frozen while not
    // running means a rollover just before a pause still produces its tick
    // after resume, and no tick is ever presented while the divider is halted.
    always_comb begin
        div_d  = div_q;
        wrap_d = wrap_q;
        tick_d = 1'b0;
        if (clr) begin
            div_d  = '0;
            wrap_d = 1'b0;
        end else if (run) begin
            if (div_q == DIV_MAX) begin
                div_d  = '0;
                wrap_d = 1'b1;
            end else begin
                div_d  = div_q + 32'd1;
                wrap_d = 1'b0;
            end
            tick_d = wrap_q;
        end
    end

    // Divider registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q  <= '0;
            wrap_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            wrap_q <= wrap_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/updown_count_controller.sv
// -----------------------------------------------------------------------------
// updown_count_controller
// Run/hold/stop sequencer that owns the count register of the up/down counting
// datapath and steps it once per divider tick.
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-low reset
//   start, pause,       : board commands; priority stop > pause > start/resume,
//   resume, stop          commands illegal in the current state are ignored
//   dir_req             : start direction (0 up, 1 down), sampled with start
//   mode                : 00 one-shot, 01 wrap, 10 ping-pong, 11 wrap
//   load_val            : initial count loaded on start
//   count               : registered count
//   tick                : registered divider strobe
//   up_en / down_en     : high in RUN_UP / RUN_DOWN
//   dir                 : current or saved direction
//   busy                : high whenever not IDLE
//   done                : one-cycle pulse when a one-shot run completes
// -----------------------------------------------------------------------------
module updown_count_controller
    import updown_ctrl_pkg::*;
#(
    parameter logic [31:0] DIV_MAX = 32'd49_999_999,
    parameter int unsigned WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             resume,
    input  logic             stop,
    input  logic             dir_req,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             up_en,
    output logic             down_en,
    output logic             dir,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    logic running;
    logic div_run;
    logic div_clr;
    logic tick_w;

    // The divider only advances on cycles that stay in RUN; a stop or pause
    // in the same cycle freezes it so HOLD resumes from the exact position.
    assign running = (state_q == RUN_UP) || (state_q == RUN_DOWN);
    assign div_run = running && !stop && !pause;
    assign div_clr = stop || ((state_q == IDLE) && start && !pause);

    tick_gen #(
        .DIV_MAX(DIV_MAX)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .run (div_run),
        .clr (div_clr),
        .tick(tick_w)
    );

    // State, count, direction and done registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            dir_q   <= DIR_UP;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Next-state and step logic. A terminal step in ping-pong mode moves away
    // from the end value and reverses direction on the same edge.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !pause) begin
                        count_d = load_val;
                        dir_d   = dir_req;
                        state_d = (dir_req == DIR_DN) ? RUN_DOWN : RUN_UP;
                    end
                end
                RUN_UP: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (tick_w) begin
                        if (count_q == CNT_MAX) begin
                            case (mode)
                                MODE_ONESHOT: begin
                                    state_d = IDLE;
                                    done_d  = 1'b1;
                                end
                                MODE_PINGPONG: begin
                                    count_d = CNT_MAX - CNT_ONE;
                                    dir_d   = DIR_DN;
                                    state_d = RUN_DOWN;
                                end
                                default: count_d = '0;
                            endcase
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                    end
                end
                RUN_DOWN: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (tick_w) begin
                        if (count_q == '0) begin
                            case (mode)
                                MODE_ONESHOT: begin
                                    state_d = IDLE;
                                    done_d  = 1'b1;
                                end
                                MODE_PINGPONG: begin
                                    count_d = CNT_ONE;
                                    dir_d   = DIR_UP;
                                    state_d = RUN_UP;
                                end
                                default: count_d = CNT_MAX;
                            endcase
                        end else begin
                            count_d = count_q - CNT_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (resume && !pause) begin
                        state_d = (dir_q == DIR_DN) ? RUN_DOWN : RUN_UP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode from the registered state.
    always_comb begin
        up_en   = (state_q == RUN_UP);
        down_en = (state_q == RUN_DOWN);
        busy    = (state_q != IDLE);
        count   = count_q;
        dir     = dir_q;
        done    = done_q;
        tick    = tick_w;
    end

endmodule

// File: tb/tb_updown_count_controller.sv
// -----------------------------------------------------------------------------
// tb_updown_count_controller
// Scoreboard bench: each applied cycle pushes the reference model's expected
// outputs into a queue, and a monitor pops and compares after every edge.
// -----------------------------------------------------------------------------
module tb_updown_count_controller;

    localparam int DIV  = 3;
    localparam int MAXV = 15;

    typedef struct packed {
        logic [3:0] count;
        logic       tick;
        logic       upEn;
        logic       downEn;
        logic       dir;
        logic       busy;
        logic       done;
    } snap_t;

    logic       clk;
    logic       rst;
    logic       start, pause, resume, stop, dirReq;
    logic [1:0] mode;
    logic [3:0] loadVal;
    logic [3:0] count;
    logic       tick, upEn, downEn, dir, busy, done;

    snap_t expQ[$];
    snap_t expNow;
    int    vectors = 0;
    int    miscompares = 0;

    // Reference model: phase 0 idle, 1 running, 2 held. The divider is
    // modelled as a count of running edges since start.
    int         mPhase = 0;
    int         mCount = 0;
    int         mEdges = 0;
    logic       mDir = 1'b0;
    logic       mDone = 1'b0;
    logic       mTick = 1'b0;
    logic [1:0] curMode = 2'b01;

    updown_count_controller #(
        .DIV_MAX(32'd3),
        .WIDTH  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pause   (pause),
        .resume  (resume),
        .stop    (stop),
        .dir_req (dirReq),
        .mode    (mode),
        .load_val(loadVal),
        .count   (count),
        .tick    (tick),
        .up_en   (upEn),
        .down_en (downEn),
        .dir     (dir),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model across the coming edge and
    // queue what the outputs must look like after it.
    task automatic applyStimulus(input logic iRst, input logic iStart, input logic iPause,
                                 input logic iResume, input logic iStop, input logic iDirReq,
                                 input logic [1:0] iMode, input logic [3:0] iLoad);
        bit    runEdge;
        bit    terminal;
        snap_t e;
        @(negedge clk);
        rst = iRst; start = iStart; pause = iPause; resume = iResume;
        stop = iStop; dirReq = iDirReq; mode = iMode; loadVal = iLoad;
        runEdge = 1'b0;
        mDone = 1'b0;
        if (!iRst) begin
            mPhase = 0; mCount = 0; mDir = 1'b0; mEdges = 0;
        end else if (iStop) begin
            mPhase = 0; mEdges = 0;
        end else if (mPhase == 1) begin
            if (iPause) begin
                mPhase = 2;
            end else begin
                runEdge = 1'b1;
                if (mTick) begin
                    terminal = (mDir == 1'b0) ? (mCount == MAXV) : (mCount == 0);
                    if (terminal && iMode == 2'b00) begin
                        mPhase = 0;
                        mDone = 1'b1;
                    end else if (terminal && iMode == 2'b10) begin
                        mDir = !mDir;
                        mCount = mDir ? mCount - 1 : mCount + 1;
                    end else begin
                        mCount = (mCount + (mDir ? MAXV : 1)) % (MAXV + 1);
                    end
                end
            end
        end else if (mPhase == 2) begin
            if (iResume && !iPause) mPhase = 1;
        end else if (iStart && !iPause) begin
            mPhase = 1; mCount = int'(iLoad); mDir = iDirReq; mEdges = 0;
        end
        if (runEdge) mEdges++;
        mTick = runEdge && (mEdges >= DIV + 2) && ((mEdges - 1) % (DIV + 1) == 0);
        e.count  = 4'(mCount);
        e.tick   = mTick;
        e.upEn   = (mPhase == 1) && !mDir;
        e.downEn = (mPhase == 1) && mDir;
        e.dir    = mDir;
        e.busy   = (mPhase != 0);
        e.done   = mDone;
        expQ.push_back(e);
        @(posedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, curMode, 4'd0);
    endtask

    // Run idle cycles until the model shows the wanted count (and a visible
    // tick if asked); an expired bound counts as a failure.
    task automatic waitForCount(input int target, input bit needTick);
        int n = 0;
        while (!(mCount == target && mPhase == 1 && (!needTick || mTick)) && n < 300) begin
            idleCycles(1);
            n++;
        end
        vectors++;
        if (n >= 300) begin
            miscompares++;
            $display("[TB] FAIL wait_count: reached count=%0d, required %0d within 300 cycles", mCount, target);
        end
    endtask

    task automatic checkOutput(input snap_t e);
        snap_t got;
        got = '{count, tick, upEn, downEn, dir, busy, done};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("[TB] FAIL outputs @%0t: got count=%0d tick=%0b up=%0b dn=%0b dir=%0b busy=%0b done=%0b, expected count=%0d tick=%0b up=%0b dn=%0b dir=%0b busy=%0b done=%0b",
                     $time, got.count, got.tick, got.upEn, got.downEn, got.dir, got.busy, got.done,
                     e.count, e.tick, e.upEn, e.downEn, e.dir, e.busy, e.done);
        end
    endtask

    // Monitor: compare one queued expectation after every edge.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            expNow = expQ.pop_front();
            checkOutput(expNow);
        end
    end

    initial begin
        logic r, s, p, rs, st;
        rst = 1'b0; start = 1'b0; pause = 1'b0; resume = 1'b0;
        stop = 1'b0; dirReq = 1'b0; mode = 2'b01; loadVal = 4'd0;

        // Reset, then wrap-mode count up from 0 through 15 and back to 0.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0);
        curMode = 2'b01;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0);
        idleCycles(80);

        // One-shot down from 2 finishing with done.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 4'd0);
        curMode = 2'b00;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'd2);
        idleCycles(20);

        // One-shot with an already-terminal load value.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd15);
        idleCycles(8);

        // Ping-pong from 14 counting up.
        curMode = 2'b10;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'd14);
        idleCycles(20);

        // Pause at 5, hold for 20 cycles, resume.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 4'd0);
        curMode = 2'b01;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0);
        waitForCount(5, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0);
        idleCycles(20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 4'd0);
        idleCycles(10);

        // Stop in the same cycle as a tick at count 7.
        waitForCount(7, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 4'd0);
        idleCycles(6);

        // Reset mid-run at count 9 with start held during reset.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd9);
        waitForCount(9, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'd3);
        idleCycles(4);

        // Randomized command traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(199) != 0);
            st = ($urandom_range(99) < 2);
            p  = ($urandom_range(99) < 4);
            s  = !p && ($urandom_range(99) < 15);
            rs = !p && ($urandom_range(99) < 15);
            applyStimulus(r, s, p, rs, st, 1'($urandom_range(1)),
                          2'($urandom_range(3)), 4'($urandom_range(15)));
        end

        idleCycles(2);
        @(posedge clk);
        #2;
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL queue_drain: %0d entries left, required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
